pipe_skid_buffer: RTL

//  Elastic two-entry pipeline register between RISC-V pipeline stages.

---
 rtl/pipe_skid_buffer_pkg.sv | 16 +
 rtl/pipe_skid_buffer_if.sv | 40 ++++
 rtl/pipe_skid_buffer_data_reg.sv | 29 ++
 rtl/pipe_skid_buffer.sv | 111 +++++++++++
 4 files changed

// File: rtl/pipe_skid_buffer_pkg.sv
// rtl/pipe_skid_buffer_pkg.sv - shared types and defaults for the pipeline skid buffer
//
// Contents:
//   skid_state_t : occupancy of the buffer (EMPTY / ONE / TWO words held)
//   XLEN         : default payload width
package pipe_pkg;

    typedef enum logic [1:0] {
        SKID_EMPTY,
        SKID_ONE,
        SKID_TWO
    } skid_state_t;

    localparam int XLEN = 32;

endpackage

// File: rtl/pipe_skid_buffer_if.sv
// rtl/pipe_skid_buffer_if.sv - valid/ready handshake bundle for the pipeline skid buffer
//
// Signals:
//   in_valid  / in_ready  / in_data  : upstream stage -> buffer
//   out_valid / out_ready / out_data : buffer -> downstream stage
// Modports:
//   slave  : the buffer side (consumes in_*, produces out_*)
//   master : the environment side (drives in_* and out_ready)
interface pipe_skid_buffer_if
    import pipe_pkg::*;
#(
    parameter int WIDTH = XLEN
) ();

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data
    );

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data
    );

endinterface

// File: rtl/pipe_skid_buffer_data_reg.sv
// rtl/pipe_skid_buffer_data_reg.sv - WIDTH-bit data register with load enable
//
// Ports:
//   clk     : rising-edge clock
//   reset_n : asynchronous active-low reset, clears q to 0
//   load    : capture d on the next rising edge
//   d       : data in
//   q       : registered data out
module pipe_data_reg
    import pipe_pkg::*;
#(
    parameter int WIDTH = XLEN
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/pipe_skid_buffer.sv
// rtl/pipe_skid_buffer.sv - two-entry elastic pipeline register with registered in_ready
//
// Ports:
//   clk     : rising-edge clock
//   reset_n : asynchronous active-low reset, empties the buffer immediately
//   flush   : synchronous flush, empties the buffer on the next edge (wins over push/pop)
//   bus     : handshake bundle (slave side): in_valid/in_ready/in_data, out_valid/out_ready/out_data
//
// The main register always feeds out_data; the skid register catches the one word
// that can arrive while the downstream stalls, because in_ready is only updated a
// cycle later.
module pipe_skid_buffer
    import pipe_pkg::*;
#(
    parameter int WIDTH = XLEN
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      flush,
    pipe_skid_buffer_if.slave         bus
);

    skid_state_t      state_q;
    skid_state_t      state_d;
    logic             push;
    logic             pop;
    logic             main_load;
    logic             skid_load;
    logic             main_sel_skid;
    logic [WIDTH-1:0] main_d;
    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] skid_q;

    // Both handshake outputs decode the state flops only, so out_ready never
    // reaches in_ready combinationally and an async reset shows up at once.
    assign bus.in_ready  = (state_q != SKID_TWO);
    assign bus.out_valid = (state_q != SKID_EMPTY);
    assign bus.out_data  = main_q;

    assign push = bus.in_valid & bus.in_ready;
    assign pop  = bus.out_valid & bus.out_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= SKID_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        main_load     = 1'b0;
        skid_load     = 1'b0;
        main_sel_skid = 1'b0;

        if (flush) begin
            // Data registers keep their stale contents; only occupancy is dropped.
            state_d = SKID_EMPTY;
        end else begin
            case (state_q)
                SKID_EMPTY: begin
                    if (push) begin
                        state_d   = SKID_ONE;
                        main_load = 1'b1;
                    end
                end
                SKID_ONE: begin
                    if (push && pop) begin
                        main_load = 1'b1;
                    end else if (push) begin
                        state_d   = SKID_TWO;
                        skid_load = 1'b1;
                    end else if (pop) begin
                        state_d = SKID_EMPTY;
                    end
                end
                SKID_TWO: begin
                    // in_ready is low here, so only a pop can happen.
                    if (pop) begin
                        state_d       = SKID_ONE;
                        main_load     = 1'b1;
                        main_sel_skid = 1'b1;
                    end
                end
                default: begin
                    state_d = SKID_EMPTY;
                end
            endcase
        end
    end

    assign main_d = main_sel_skid ? skid_q : bus.in_data;

    pipe_data_reg #(.WIDTH(WIDTH)) u_main (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (main_load),
        .d       (main_d),
        .q       (main_q)
    );

    pipe_data_reg #(.WIDTH(WIDTH)) u_skid (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (skid_load),
        .d       (bus.in_data),
        .q       (skid_q)
    );

endmodule
